// File: rtl/sr_ff_pkg.sv
// Shared mode encodings and FSM state type for the flip-flop bank.
package sr_ff_pkg;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

endpackage

// File: rtl/sr_ff_cell.sv
// One flip-flop channel's next-state logic. Purely combinational; the register lives in the top.
// In SR mode with a=b=1 the bit holds and the illegal flag is raised.
module sr_ff_cell
  import sr_ff_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       q,
  output logic       q_next,
  output logic       illegal
);

  // Per-mode next-state and illegal-input decode.
  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    case (mode)
      MODE_SR: begin
        case ({a, b})
          2'b10:   q_next = 1'b1;
          2'b01:   q_next = 1'b0;
          2'b11:   illegal = 1'b1;
          default: q_next = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   q_next = 1'b1;
          2'b01:   q_next = 1'b0;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = a;
      default: q_next = q ^ a;
    endcase
  end

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH flip-flops with run-time SR/JK/D/T mode, sticky illegal-input flags,
// a saturating illegal-event counter and an optional freeze-on-fault state.
//
//   state | meaning
//   RUN   | normal operation, q updates when en=1
//   FAULT | illegal SR input seen with STRICT=1; q frozen until clr_err
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               STRICT  = 0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] err_vec,
  output logic             fault,
  output logic [CNT_W-1:0] err_cnt
);

  localparam bit STRICT_B = (STRICT != 0);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_cell;
  logic [WIDTH-1:0] ill_bits;
  logic             upd;
  logic             ill_evt;
  logic [WIDTH-1:0] ill_new;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell u_cell (
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q[i]),
      .q_next  (q_cell[i]),
      .illegal (ill_bits[i])
    );
  end

  // Updates and illegal detection only happen while running with en=1.
  assign upd     = en && (state == RUN);
  assign ill_new = upd ? ill_bits : '0;
  assign ill_evt = |ill_new;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next-state: a clear and a fresh illegal event on the same edge lands in FAULT (set wins).
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (STRICT_B && ill_evt) state_nxt = FAULT;
      FAULT:   if (clr_err)             state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // q register: strict mode suppresses the whole update on an illegal event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (upd && !(STRICT_B && ill_evt)) begin
      q <= q_cell;
    end
  end

  // Sticky illegal flags; clr_err wipes old flags but new ones from the same edge survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_vec <= '0;
    else if (clr_err) err_vec <= ill_new;
    else              err_vec <= err_vec | ill_new;
  end

  // Event counter: one count per cycle with any illegal bit, saturating, reset-only clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (ill_evt && (err_cnt != {CNT_W{1'b1}}))
      err_cnt <= err_cnt + CNT_W'(1);
  end

  assign qn    = ~q;
  assign fault = STRICT_B ? (state == FAULT) : 1'b0;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: three 4-bit instances (STRICT=0, STRICT=1, CNT_W=2)
// driven from a table of vectors plus hand-written reset sequences.
module tb_sr_ff_bank;
  import sr_ff_pkg::*;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] en;
  logic [2:0] clr;
  logic [1:0] mode [3];
  logic [W-1:0] a [3];
  logic [W-1:0] b [3];
  logic [W-1:0] q [3];
  logic [W-1:0] qn [3];
  logic [W-1:0] ev [3];
  logic [2:0]   flt;
  logic [7:0]   cnt0, cnt1;
  logic [1:0]   cnt2;
  logic [7:0]   cnt [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(W), .RST_VAL(4'b0000), .STRICT(0), .CNT_W(8)) u_s0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .mode(mode[0]), .a(a[0]), .b(b[0]),
    .clr_err(clr[0]), .q(q[0]), .qn(qn[0]), .err_vec(ev[0]), .fault(flt[0]), .err_cnt(cnt0));

  sr_ff_bank #(.WIDTH(W), .RST_VAL(4'b0000), .STRICT(1), .CNT_W(8)) u_s1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .mode(mode[1]), .a(a[1]), .b(b[1]),
    .clr_err(clr[1]), .q(q[1]), .qn(qn[1]), .err_vec(ev[1]), .fault(flt[1]), .err_cnt(cnt1));

  sr_ff_bank #(.WIDTH(W), .RST_VAL(4'b0000), .STRICT(0), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .mode(mode[2]), .a(a[2]), .b(b[2]),
    .clr_err(clr[2]), .q(q[2]), .qn(qn[2]), .err_vec(ev[2]), .fault(flt[2]), .err_cnt(cnt2));

  assign cnt[0] = cnt0;
  assign cnt[1] = cnt1;
  assign cnt[2] = {6'b0, cnt2};

  typedef struct {
    string        name;
    int           dut;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_ev;
    logic         exp_flt;
    logic [7:0]   exp_cnt;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0; clr[k] = 1'b0; mode[k] = MODE_SR; a[k] = '0; b[k] = '0;
    end
  endtask

  task automatic chk_state(input string tag, input int k, input logic [W-1:0] eq,
                           input logic [W-1:0] eev, input logic ef, input logic [7:0] ec);
    chk({tag, ".q"},     {4'b0, q[k]},  {4'b0, eq});
    chk({tag, ".qn"},    {4'b0, qn[k]}, {4'b0, ~eq});
    chk({tag, ".err"},   {4'b0, ev[k]}, {4'b0, eev});
    chk({tag, ".fault"}, {7'b0, flt[k]}, {7'b0, ef});
    chk({tag, ".cnt"},   cnt[k], ec);
  endtask

  function automatic vec_t mk(string nm, int d, logic e, logic [1:0] m, logic [W-1:0] va,
                              logic [W-1:0] vb, logic c, logic [W-1:0] eq, logic [W-1:0] eev,
                              logic ef, logic [7:0] ec);
    vec_t v;
    v.name = nm; v.dut = d; v.en = e; v.mode = m; v.a = va; v.b = vb; v.clr = c;
    v.exp_q = eq; v.exp_ev = eev; v.exp_flt = ef; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    idle_all();

    // STRICT=0 basic SR, hold, enable, partial update on illegal, JK/T/D.
    vecs.push_back(mk("s0_sr_set",   0, 1, MODE_SR, 4'b0001, 4'b0010, 0, 4'b0001, 4'b0000, 0, 8'd0));
    vecs.push_back(mk("s0_sr_hold",  0, 1, MODE_SR, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 0, 8'd0));
    vecs.push_back(mk("s0_en_off",   0, 0, MODE_SR, 4'b1111, 4'b0000, 0, 4'b0001, 4'b0000, 0, 8'd0));
    vecs.push_back(mk("s0_sr_ill",   0, 1, MODE_SR, 4'b1010, 4'b1001, 0, 4'b0010, 4'b1000, 0, 8'd1));
    vecs.push_back(mk("s0_d_0101",   0, 1, MODE_D,  4'b0101, 4'b1111, 0, 4'b0101, 4'b1000, 0, 8'd1));
    vecs.push_back(mk("s0_jk_tog",   0, 1, MODE_JK, 4'b1111, 4'b1111, 0, 4'b1010, 4'b1000, 0, 8'd1));
    vecs.push_back(mk("s0_t_0011",   0, 1, MODE_T,  4'b0011, 4'b1111, 0, 4'b1001, 4'b1000, 0, 8'd1));
    vecs.push_back(mk("s0_d_0110",   0, 1, MODE_D,  4'b0110, 4'b0000, 0, 4'b0110, 4'b1000, 0, 8'd1));
    vecs.push_back(mk("s0_clr",      0, 0, MODE_SR, 4'b0000, 4'b0000, 1, 4'b0110, 4'b0000, 0, 8'd1));
    vecs.push_back(mk("s0_jk_mix",   0, 1, MODE_JK, 4'b1001, 4'b0110, 0, 4'b1001, 4'b0000, 0, 8'd1));
    // STRICT=1: freeze, clear, same-edge clear+illegal.
    vecs.push_back(mk("s1_sr_set",   1, 1, MODE_SR, 4'b0001, 4'b0010, 0, 4'b0001, 4'b0000, 0, 8'd0));
    vecs.push_back(mk("s1_sr_ill",   1, 1, MODE_SR, 4'b1010, 4'b1001, 0, 4'b0001, 4'b1000, 1, 8'd1));
    vecs.push_back(mk("s1_frozen",   1, 1, MODE_D,  4'b1111, 4'b0000, 0, 4'b0001, 4'b1000, 1, 8'd1));
    vecs.push_back(mk("s1_clr",      1, 0, MODE_SR, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 0, 8'd1));
    vecs.push_back(mk("s1_d_1111",   1, 1, MODE_D,  4'b1111, 4'b0000, 0, 4'b1111, 4'b0000, 0, 8'd1));
    vecs.push_back(mk("s1_clr_ill",  1, 1, MODE_SR, 4'b0001, 4'b0001, 1, 4'b1111, 4'b0001, 1, 8'd2));
    vecs.push_back(mk("s1_clr2",     1, 0, MODE_SR, 4'b0000, 4'b0000, 1, 4'b1111, 4'b0000, 0, 8'd2));
    // CNT_W=2 saturation.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk($sformatf("c2_ill%0d", i), 2, 1, MODE_SR, 4'b0001, 4'b0001, 0,
                        4'b0000, 4'b0001, 0, (i < 3) ? 8'(i + 1) : 8'd3));
    vecs.push_back(mk("c2_clr",      2, 0, MODE_SR, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'd3));

    // Reset state for all instances.
    #12;
    for (int k = 0; k < 3; k++) chk_state($sformatf("rst%0d", k), k, 4'b0000, 4'b0000, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-run asynchronous reset: load q=1011 plus some error history, then pulse rst_n between edges.
    @(negedge clk);
    en[0] = 1'b1; mode[0] = MODE_SR; a[0] = 4'b1000; b[0] = 4'b1000;
    @(posedge clk); #1;
    en[0] = 1'b1; mode[0] = MODE_D; a[0] = 4'b1011; b[0] = 4'b0000;
    @(posedge clk); #1;
    chk_state("pre_rst", 0, 4'b1011, 4'b1000, 0, 8'd1);
    idle_all();
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 0, 4'b0000, 4'b0000, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors: drive just after an edge, check just after the next one.
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      idle_all();
      en[vecs[i].dut]   = vecs[i].en;
      mode[vecs[i].dut] = vecs[i].mode;
      a[vecs[i].dut]    = vecs[i].a;
      b[vecs[i].dut]    = vecs[i].b;
      clr[vecs[i].dut]  = vecs[i].clr;
      @(posedge clk); #1;
      chk_state(vecs[i].name, vecs[i].dut, vecs[i].exp_q, vecs[i].exp_ev,
                vecs[i].exp_flt, vecs[i].exp_cnt);
    end

    idle_all();
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
